pat_check: RTL and testbench

PAT_CHECK -- requirements
Module: pat_check

---
 rtl/pat_check.sv | 132 +++++++++++++
 tb/tb_pat_check.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pat_check.sv
`timescale 1ns / 1ps
// pat_check: serial pattern checker. Aligns to a repeating PAT_LEN-bit pattern,
// then counts bit errors and completed periods until REPEAT_NUM periods are done.
// All outputs are registered; there is no combinational path from D.
module pat_check #(
    parameter int unsigned          PAT_LEN    = 7,
    parameter logic [PAT_LEN-1:0]   PATTERN    = 7'b1001010,
    parameter int unsigned          REPEAT_NUM = 100,
    parameter int unsigned          LOSS_THR   = 3
) (
    input  logic        CK,
    input  logic        RSTB,
    input  logic        EN,
    input  logic        D,
    output logic        LOCK,
    output logic        ERR,
    output logic [15:0] ERR_CNT,
    output logic [15:0] PER_CNT,
    output logic        DONE
);

    localparam int unsigned PTR_W = (PAT_LEN > 1) ? $clog2(PAT_LEN) : 1;
    // Shared width for the fill and consecutive-miss counters (LOSS_THR <= PAT_LEN).
    localparam int unsigned CNT_W = $clog2(PAT_LEN + 1);

    localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(PAT_LEN - 1);
    localparam logic [CNT_W-1:0] FILL_FULL = CNT_W'(PAT_LEN);
    localparam logic [CNT_W-1:0] MISS_LAST = CNT_W'(LOSS_THR - 1);
    localparam logic [15:0]      PER_LAST  = 16'(REPEAT_NUM - 1);

    typedef enum logic [1:0] {
        StSearch,
        StLocked,
        StFinished
    } state_t;

    state_t             r_state;
    logic [PAT_LEN-1:0] r_sr;
    logic [CNT_W-1:0]   r_fill;
    logic [PTR_W-1:0]   r_ptr;
    logic [CNT_W-1:0]   r_miss;
    logic               r_lock;
    logic               r_err;
    logic [15:0]        r_err_cnt;
    logic [15:0]        r_per_cnt;
    logic               r_done;

    logic [PAT_LEN-1:0] w_sr_next;
    logic [CNT_W-1:0]   w_fill_next;
    logic               w_mismatch;
    logic               w_wrap;
    logic               w_loss;
    logic               w_final;
    logic [15:0]        w_err_cnt_next;

    // Window shifts toward bit 0 so sr[0] is the oldest sample, matching PATTERN[0].
    assign w_sr_next      = {D, r_sr[PAT_LEN-1:1]};
    assign w_fill_next    = (r_fill == FILL_FULL) ? r_fill : r_fill + 1'b1;
    assign w_mismatch     = D ^ PATTERN[r_ptr];
    assign w_wrap         = (r_ptr == PTR_LAST);
    assign w_loss         = w_mismatch && (r_miss == MISS_LAST);
    assign w_final        = w_wrap && (r_per_cnt == PER_LAST);
    assign w_err_cnt_next = (r_err_cnt == 16'hFFFF) ? r_err_cnt : r_err_cnt + 16'd1;

    // Main FSM: alignment search, locked compare/count, and sticky completion.
    always_ff @(posedge CK) begin
        if (!RSTB) begin
            r_state   <= StSearch;
            r_sr      <= '0;
            r_fill    <= '0;
            r_ptr     <= '0;
            r_miss    <= '0;
            r_lock    <= 1'b0;
            r_err     <= 1'b0;
            r_err_cnt <= '0;
            r_per_cnt <= '0;
            r_done    <= 1'b0;
        end else begin
            r_err <= 1'b0;
            if (EN) begin
                unique case (r_state)
                    StSearch: begin
                        r_sr   <= w_sr_next;
                        r_fill <= w_fill_next;
                        if ((w_fill_next == FILL_FULL) && (w_sr_next == PATTERN)) begin
                            r_state <= StLocked;
                            r_lock  <= 1'b1;
                            r_ptr   <= '0;
                            r_miss  <= '0;
                        end
                    end
                    StLocked: begin
                        r_sr   <= w_sr_next;
                        r_fill <= w_fill_next;
                        r_ptr  <= w_wrap ? '0 : r_ptr + 1'b1;
                        if (w_mismatch) begin
                            r_err     <= 1'b1;
                            r_err_cnt <= w_err_cnt_next;
                            r_miss    <= r_miss + 1'b1;
                        end else begin
                            r_miss <= '0;
                        end
                        if (w_wrap) begin
                            r_per_cnt <= r_per_cnt + 16'd1;
                        end
                        // Completion wins over loss of lock on the same sample.
                        if (w_final) begin
                            r_state <= StFinished;
                            r_lock  <= 1'b0;
                            r_done  <= 1'b1;
                        end else if (w_loss) begin
                            r_state <= StSearch;
                            r_lock  <= 1'b0;
                            r_fill  <= '0;
                            r_miss  <= '0;
                        end
                    end
                    default: begin
                        // StFinished: everything frozen until reset.
                    end
                endcase
            end
        end
    end

    assign LOCK    = r_lock;
    assign ERR     = r_err;
    assign ERR_CNT = r_err_cnt;
    assign PER_CNT = r_per_cnt;
    assign DONE    = r_done;

endmodule

// File: tb/tb_pat_check.sv
`timescale 1ns / 1ps
// tb_pat_check: scoreboard bench for pat_check with default parameters.
module tb_pat_check;

    logic        CK;
    logic        RSTB;
    logic        EN;
    logic        D;
    logic        LOCK;
    logic        ERR;
    logic [15:0] ERR_CNT;
    logic [15:0] PER_CNT;
    logic        DONE;

    pat_check dut (
        .CK      (CK),
        .RSTB    (RSTB),
        .EN      (EN),
        .D       (D),
        .LOCK    (LOCK),
        .ERR     (ERR),
        .ERR_CNT (ERR_CNT),
        .PER_CNT (PER_CNT),
        .DONE    (DONE)
    );

    initial CK = 1'b0;
    always #5 CK = ~CK;

    typedef struct packed {
        logic        lock;
        logic        err;
        logic [15:0] err_cnt;
        logic [15:0] per_cnt;
        logic        done;
    } exp_t;

    exp_t        exp_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [6:0]  pat     = 7'b1001010;
    int          ph      = 0;

    // Reference model state
    int          m_state;
    int          m_fill;
    int          m_ptr;
    int          m_miss;
    int          m_err_cnt;
    int          m_per_cnt;
    logic        m_lock;
    logic        m_err;
    logic        m_done;
    logic [6:0]  m_win;

    task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input logic rstb, input logic en, input logic d);
        logic mis;
        if (!rstb) begin
            m_state = 0; m_fill = 0; m_ptr = 0; m_miss = 0;
            m_err_cnt = 0; m_per_cnt = 0;
            m_lock = 0; m_err = 0; m_done = 0; m_win = '0;
            return;
        end
        m_err = 0;
        if (!en || m_state == 2) return;
        m_win = {d, m_win[6:1]};
        if (m_fill < 7) m_fill++;
        if (m_state == 0) begin
            if (m_fill == 7 && m_win == pat) begin
                m_state = 1; m_lock = 1; m_ptr = 0; m_miss = 0;
            end
        end else begin
            mis = (d != pat[m_ptr]);
            if (mis) begin
                m_err = 1;
                if (m_err_cnt < 65535) m_err_cnt++;
                m_miss++;
            end else begin
                m_miss = 0;
            end
            if (m_ptr == 6) begin
                m_ptr = 0;
                m_per_cnt++;
                if (m_per_cnt == 100) begin
                    m_state = 2; m_lock = 0; m_done = 1;
                    return;
                end
            end else begin
                m_ptr++;
            end
            if (m_miss == 3) begin
                m_state = 0; m_lock = 0; m_fill = 0; m_miss = 0;
            end
        end
    endtask

    // One clock: drive inputs, push the model's prediction, compare after the edge.
    task automatic step(input logic rstb, input logic en, input logic d);
        exp_t e;
        RSTB = rstb;
        EN   = en;
        D    = d;
        model_step(rstb, en, d);
        e.lock    = m_lock;
        e.err     = m_err;
        e.err_cnt = 16'(m_err_cnt);
        e.per_cnt = 16'(m_per_cnt);
        e.done    = m_done;
        exp_q.push_back(e);
        @(posedge CK);
        #1;
        e = exp_q.pop_front();
        check_eq("sb_lock", LOCK, e.lock);
        check_eq("sb_err", ERR, e.err);
        check_eq("sb_err_cnt", ERR_CNT, e.err_cnt);
        check_eq("sb_per_cnt", PER_CNT, e.per_cnt);
        check_eq("sb_done", DONE, e.done);
    endtask

    task automatic send_pat(input int n);
        for (int i = 0; i < n; i++) begin
            step(1'b1, 1'b1, pat[ph]);
            ph = (ph + 1) % 7;
        end
    endtask

    task automatic do_reset();
        step(1'b0, 1'b1, 1'($urandom_range(1)));
        step(1'b0, 1'b0, 1'($urandom_range(1)));
        ph = 0;
    endtask

    initial begin
        int err_seen;
        int held;
        RSTB = 1'b0;
        EN   = 1'b0;
        D    = 1'b0;
        model_step(1'b0, 1'b0, 1'b0);

        // Reset state
        do_reset();
        check_eq("rst_lock", LOCK, 0);
        check_eq("rst_done", DONE, 0);
        check_eq("rst_err_cnt", ERR_CNT, 0);
        check_eq("rst_per_cnt", PER_CNT, 0);

        // Clean lock through completion
        send_pat(6);
        check_eq("clean_nolock6", LOCK, 0);
        send_pat(1);
        check_eq("clean_lock7", LOCK, 1);
        send_pat(6);
        check_eq("clean_per0", PER_CNT, 0);
        send_pat(1);
        check_eq("clean_per1", PER_CNT, 1);
        send_pat(706 - 14);
        check_eq("clean_notdone706", DONE, 0);
        send_pat(1);
        check_eq("clean_done", DONE, 1);
        check_eq("clean_per100", PER_CNT, 100);
        check_eq("clean_err0", ERR_CNT, 0);
        check_eq("clean_unlock", LOCK, 0);
        step(1'b1, 1'b1, ~pat[ph]);
        step(1'b1, 1'b1, ~pat[ph]);
        check_eq("fin_frozen_err", ERR_CNT, 0);
        check_eq("fin_frozen_per", PER_CNT, 100);

        // Misaligned start at PATTERN[3]
        do_reset();
        ph = 3;
        err_seen = 0;
        for (int i = 0; i < 10; i++) begin
            send_pat(1);
            err_seen += int'(ERR);
        end
        check_eq("mis_nolock10", LOCK, 0);
        send_pat(1);
        check_eq("mis_lock11", LOCK, 1);
        send_pat(10);
        err_seen += int'(ERR);
        check_eq("mis_no_err", err_seen, 0);

        // Single inverted bit while locked
        do_reset();
        send_pat(10);
        step(1'b1, 1'b1, ~pat[ph]);
        ph = (ph + 1) % 7;
        err_seen = 0;
        for (int i = 0; i < 14; i++) begin
            if (i == 0) err_seen += int'(ERR);
            send_pat(1);
            err_seen += int'(ERR);
        end
        check_eq("single_pulses", err_seen, 1);
        check_eq("single_err_cnt", ERR_CNT, 1);
        check_eq("single_lock", LOCK, 1);

        // Loss of lock: three consecutive inversions, then relock
        do_reset();
        send_pat(17);
        held = int'(PER_CNT);
        for (int i = 0; i < 3; i++) begin
            if (i == 2) check_eq("loss_lock_before3", LOCK, 1);
            step(1'b1, 1'b1, ~pat[ph]);
            ph = (ph + 1) % 7;
        end
        check_eq("loss_lock", LOCK, 0);
        check_eq("loss_err_cnt", ERR_CNT, 3);
        check_eq("loss_per_held", PER_CNT, held);
        for (int i = 0; i < 20 && !LOCK; i++) send_pat(1);
        check_eq("relock", LOCK, 1);
        check_eq("relock_per_held", PER_CNT, held);
        send_pat(7);
        check_eq("relock_per_resume", PER_CNT, held + 1);

        // EN gating: toggle EN every cycle
        do_reset();
        err_seen = 0;
        for (int i = 0; i < 26; i++) begin
            if (i % 2 == 0) begin
                send_pat(1);
            end else begin
                step(1'b1, 1'b0, 1'($urandom_range(1)));
            end
            err_seen += int'(ERR);
            if (i == 11) check_eq("en_nolock", LOCK, 0);
            if (i == 12) check_eq("en_lock", LOCK, 1);
            if (i == 24) check_eq("en_per0", PER_CNT, 0);
        end
        send_pat(1);
        check_eq("en_per1", PER_CNT, 1);
        check_eq("en_no_err", err_seen, 0);

        // Mid-run reset at PER_CNT=40, then a full run
        do_reset();
        send_pat(7 + 40 * 7);
        check_eq("mid_per40", PER_CNT, 40);
        step(1'b0, 1'b1, 1'($urandom_range(1)));
        ph = 0;
        check_eq("mid_rst_lock", LOCK, 0);
        check_eq("mid_rst_per", PER_CNT, 0);
        check_eq("mid_rst_err", ERR, 0);
        send_pat(707);
        check_eq("mid_done", DONE, 1);
        check_eq("mid_per100", PER_CNT, 100);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
